dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory port.
- Services the mem_read / mem_write requests that the decoded control word drives out of the MEM stage.
- Backing store is a word-addressed, byte-maskable array; each request gets a single-cycle mem_resp after a fixed, parameterised latency.
- Used as the data memory in simulation and FPGA bring-up, and as the reference model the cache must match.

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder_array.sv | 44 ++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// +--------------------------------------------------------------------------+
// | rv32i_types : shared types and constants for the data-memory responder   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

  localparam int DMEM_LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Lane masks a naturally aligned byte, halfword or word store can produce.
  function automatic logic dmem_be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: dmem_be_legal = 1'b1;
      default:                   dmem_be_legal = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// +--------------------------------------------------------------------------+
// | dmem_if : MEM-stage data-memory request/response bundle                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dmem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata, mem_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder_array.sv
// +--------------------------------------------------------------------------+
// | dmem_array : DEPTH x 32 synchronous RAM, per-byte write, one read port   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // Storage is deliberately left unreset; only the read register clears.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +--------------------------------------------------------------------------+
// | dmem_responder : fixed-latency data-memory responder for the MEM stage   |
// | Optional macro DMEM_ALIGN_CHECK_EN adds alignment / lane-mask checking.  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_responder
  import rv32i_types::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam logic [DMEM_LAT_W-1:0] c_LAT_M1 = DMEM_LAT_W'(LATENCY - 1);
  localparam logic [DMEM_LAT_W-1:0] c_ONE    = DMEM_LAT_W'(1);

  dmem_state_t           state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  is_wr_q, is_wr_d;
  logic                  is_rd_q, is_rd_d;
  logic                  err_q, err_d;

  logic                  w_req;
  logic                  w_chk_err;
  logic [3:0]            w_we;
  logic                  w_re;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_req = bus.mem_read | bus.mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_chk_err = (bus.mem_address[1:0] != 2'b00) |
                     (bus.mem_write & ~dmem_be_legal(bus.mem_byte_enable));
`else
  assign w_chk_err = 1'b0;
`endif

  assign w_unused = ^{bus.mem_address[31:DEPTH_LOG2+2], bus.mem_address[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    is_wr_d = is_wr_q;
    is_rd_d = is_rd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          idx_d   = bus.mem_address[DEPTH_LOG2+1:2];
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_byte_enable;
          // A simultaneous read+write is serviced as a write only.
          is_wr_d = bus.mem_write;
          is_rd_d = bus.mem_read & ~bus.mem_write;
          cnt_d   = c_LAT_M1;
          err_d   = err_q | (bus.mem_read & bus.mem_write) | w_chk_err;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - c_ONE;
        if (cnt_q == c_ONE) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
      is_rd_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      is_rd_q <= is_rd_d;
      err_q   <= err_d;
    end
  end

  // Read data is captured on the edge that enters RESP; the write commits on
  // the edge that leaves it, and reset on that edge cancels the commit.
  assign w_re = (state_d == RESP) && (state_q != RESP) && is_rd_d;
  assign w_we = (state_q == RESP && is_wr_q && !rst) ? be_q : 4'b0000;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .re_i    (w_re),
    .raddr_i (idx_d),
    .rdata_o (w_rdata)
  );

  assign bus.mem_resp  = (state_q == RESP) & ~rst;
  assign bus.mem_rdata = w_rdata;
  assign bus.mem_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +--------------------------------------------------------------------------+
// | tb_dmem_responder : directed + random bench with a word-array model      |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst;
  dmem_if bus ();

  dmem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LATENCY    (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model [DEPTH];
  logic        err_model;
  logic [31:0] rdata_model;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic req_err(input bit rd, input bit wr,
                                   input logic [31:0] a, input logic [3:0] be);
    logic e;
    e = rd && wr;
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % 4 != 0) e = 1'b1;
    if (wr && !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b0011, 4'b1100, 4'b1111})) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One complete transaction: drive, wait for the response, compare, release.
  task automatic req(input string tag, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be);
    int lat;
    @(posedge clk); #1;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = a;
    bus.mem_wdata       = wd;
    bus.mem_byte_enable = be;
    if (rd && !wr) rdata_model = model[idx_of(a)];
    err_model = err_model | req_err(rd, wr, a, be);
    lat = -1;
    for (int k = 0; k <= LATENCY + 4; k++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(LATENCY));
    check({tag, " rdata"}, bus.mem_rdata, rdata_model);
    check({tag, " err"}, 32'(bus.mem_err), 32'(err_model));
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[idx_of(a)][8*i +: 8] = wd[8*i +: 8];
    end
    @(negedge clk);
    check({tag, " pulse width"}, 32'(bus.mem_resp), 32'd0);
  endtask

  initial begin
    logic [31:0] a3 [4];
    logic [31:0] a;
    int          j, last, acc, nresp;

    rst                 = 1'b1;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    err_model           = 1'b0;
    rdata_model         = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset resp", 32'(bus.mem_resp), 32'd0);
    check("reset rdata", bus.mem_rdata, 32'h0);
    check("reset err", 32'(bus.mem_err), 32'd0);

    // Full-word write then read back.
    req("t1 wr", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    req("t1 rd", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("t1 value", bus.mem_rdata, 32'hDEADBEEF);

    // Partial-lane merge.
    req("t2 pre", 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    req("t2 wr", 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    req("t2 rd", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    check("t2 value", bus.mem_rdata, 32'h11BB33DD);

    // Random traffic over a small window, including aliased (wrapped) addresses.
    for (int i = 0; i < 8; i++)
      req("pre", 1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 24; i++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a + 32'(DEPTH * 4);
      if ($urandom_range(0, 1) == 0)
        req("rnd rd", 1'b1, 1'b0, a, 32'h0, 4'h0);
      else
        req("rnd wr", 1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Back-to-back reads held high; address is disturbed during BUSY.
    a3[0] = 32'h100; a3[1] = 32'h10C; a3[2] = 32'h10; a3[3] = 32'h118;
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = a3[0];
    j = 0; last = 0; acc = 0;
    for (int k = 1; k <= 4 * (LATENCY + 1) + 10 && j < 4; k++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        check("b2b data", bus.mem_rdata, model[idx_of(a3[j])]);
        if (j == 0) check("b2b first", 32'(k), 32'(LATENCY));
        else        check("b2b spacing", 32'(k - last), 32'(LATENCY + 1));
        last = k;
        j++;
        if (j < 4) bus.mem_address = a3[j];
        else       bus.mem_read = 1'b0;
        acc = k + 1;
      end else if (k == acc + 1) begin
        bus.mem_address = a3[j] + 32'h40;
      end
    end
    bus.mem_read = 1'b0;
    check("b2b count", 32'(j), 32'd4);
    rdata_model = model[idx_of(a3[3])];
    @(negedge clk);

    // Read and write together: write wins, error is sticky.
    req("t4 rw", 1'b1, 1'b1, 32'h40, 32'h5, 4'hF);
    req("t4 rd", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    check("t4 value", bus.mem_rdata, 32'h5);
    check("t4 sticky", 32'(bus.mem_err), 32'd1);

    // Reset during BUSY drops the pending write.
    req("t5 pre", 1'b0, 1'b1, 32'h80, 32'h0, 4'hF);
    @(posedge clk); #1;
    bus.mem_write       = 1'b1;
    bus.mem_address     = 32'h80;
    bus.mem_wdata       = 32'hCAFEF00D;
    bus.mem_byte_enable = 4'hF;
    nresp = 0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (bus.mem_resp) nresp++;
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        rst           = 1'b0;
        bus.mem_write = 1'b0;
      end
    end
    check("t5 no resp", 32'(nresp), 32'd0);
    check("t5 err cleared", 32'(bus.mem_err), 32'd0);
    check("t5 rdata cleared", bus.mem_rdata, 32'h0);
    err_model   = 1'b0;
    rdata_model = 32'h0;
    req("t5 rd", 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    check("t5 value", bus.mem_rdata, 32'h0);

    // Misaligned read returns the containing word.
    req("t6 rd", 1'b1, 1'b0, 32'h42, 32'h0, 4'h0);
    check("t6 value", bus.mem_rdata, 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
